// File: rtl/word_bit_serializer_if.sv
// Handshake and serial-stream bundle for word_bit_serializer.
// The master drives words and stall; the slave (the serializer) returns the stream.
interface word_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_last;
  logic [1:0]       exp_par;
  logic             busy;

  modport master (
    output in_data, in_valid, stall,
    input  in_ready, bit_out, bit_valid, bit_last, exp_par, busy
  );

  modport slave (
    input  in_data, in_valid, stall,
    output in_ready, bit_out, bit_valid, bit_last, exp_par, busy
  );
endinterface

// File: rtl/word_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out,
// framed by bit_valid/bit_last, with an expected 0s/1s parity tag per word.
module word_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  word_bit_serializer_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("word_bit_serializer: WIDTH must be in 2..32");
  end

  localparam logic [4:0] LAST_CNT  = 5'(WIDTH - 1);
  localparam logic       WIDTH_ODD = 1'(WIDTH % 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] sreg;
  logic [1:0]       exp_par_q;
  logic             at_last;
  logic             xfer;
  logic             word_par;

  // Handshake and stream framing are combinational so back-to-back words need no bubble.
  assign at_last       = (state == SHIFT) && (cnt == LAST_CNT);
  assign bus.in_ready  = !rst && ((state == IDLE) || (at_last && !bus.stall));
  assign bus.bit_valid = (state == SHIFT) && !bus.stall;
  assign bus.bit_last  = bus.bit_valid && (cnt == LAST_CNT);
  assign bus.bit_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign bus.busy      = (state == SHIFT);
  assign bus.exp_par   = exp_par_q;
  assign xfer          = bus.in_valid && bus.in_ready;
  assign word_par      = ^bus.in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      sreg      <= '0;
      exp_par_q <= 2'b00;
    end else if (xfer) begin
      state     <= SHIFT;
      cnt       <= 5'd0;
      sreg      <= bus.in_data;
      exp_par_q <= {word_par ^ WIDTH_ODD, word_par};
    end else if ((state == SHIFT) && !bus.stall) begin
      if (cnt == LAST_CNT) begin
        state <= IDLE;
        cnt   <= 5'd0;
        sreg  <= '0;
      end else begin
        cnt <= cnt + 5'd1;
        if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
        else           sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_word_bit_serializer.sv
// Directed bench for word_bit_serializer: an MSB-first WIDTH=8 instance and an
// LSB-first WIDTH=5 instance, checked cycle by cycle against hand-computed streams.
module tb_word_bit_serializer;

  logic clk = 1'b0;
  logic rst8;
  logic rst5;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  word_bit_serializer_if #(.WIDTH(8)) bus8 ();
  word_bit_serializer_if #(.WIDTH(5)) bus5 ();

  word_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8.slave)
  );

  word_bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) dut5 (
    .clk (clk),
    .rst (rst5),
    .bus (bus5.slave)
  );

  // observed vector order: {bit_valid, bit_out, bit_last, in_ready, busy}
  task automatic test_reset;
    rst8 = 1'b1; rst5 = 1'b1;
    bus8.in_data = '0; bus8.in_valid = 1'b0; bus8.stall = 1'b0;
    bus5.in_data = '0; bus5.in_valid = 1'b0; bus5.stall = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({bus8.in_ready, bus8.bit_valid, bus8.bit_last, bus8.bit_out, bus8.busy, bus8.exp_par} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset8: got %b want 0000000", {bus8.in_ready, bus8.bit_valid, bus8.bit_last, bus8.bit_out, bus8.busy, bus8.exp_par});
    end
    vectors++;
    if ({bus5.in_ready, bus5.bit_valid, bus5.bit_last, bus5.bit_out, bus5.busy, bus5.exp_par} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset5: got %b want 0000000", {bus5.in_ready, bus5.bit_valid, bus5.bit_last, bus5.bit_out, bus5.busy, bus5.exp_par});
    end
    @(negedge clk); rst8 = 1'b0; rst5 = 1'b0; #1;
    vectors++;
    if ({bus8.in_ready, bus8.busy, bus5.in_ready, bus5.busy} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 1010", {bus8.in_ready, bus8.busy, bus5.in_ready, bus5.busy});
    end
  endtask

  task automatic test_single_word;
    logic [7:0] w = 8'b0110_0001;
    logic [4:0] exp;
    @(negedge clk); bus8.in_data = w; bus8.in_valid = 1'b1; #1;
    vectors++;
    if ({bus8.in_ready, bus8.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_accept: got %b want 10", {bus8.in_ready, bus8.busy});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus8.in_valid = 1'b0; #1;
      exp = {1'b1, w[7-i], i == 7, i == 7, 1'b1};
      vectors++;
      if ({bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy} !== exp) begin
        miscompares++;
        $display("FAIL single_bit%0d: got %b want %b", i, {bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy}, exp);
      end
      if (i == 7) begin
        vectors++;
        if (bus8.exp_par !== 2'b11) begin
          miscompares++;
          $display("FAIL single_exp_par: got %b want 11", bus8.exp_par);
        end
      end
    end
    @(negedge clk); #1;
    vectors++;
    if ({bus8.bit_valid, bus8.busy, bus8.in_ready, bus8.bit_out} !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_idle: got %b want 0010", {bus8.bit_valid, bus8.busy, bus8.in_ready, bus8.bit_out});
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp;
    logic       b;
    @(negedge clk); bus8.in_data = 8'hFF; bus8.in_valid = 1'b1; #1;
    vectors++;
    if (bus8.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: got %b want 1", bus8.in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus8.in_data  = 8'h00;
      bus8.in_valid = (i < 8);
      #1;
      b   = (i < 8);
      exp = {1'b1, b, (i == 7) || (i == 15), (i == 7) || (i == 15), 1'b1};
      vectors++;
      if ({bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy} !== exp) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: got %b want %b", i, {bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy}, exp);
      end
      if (i == 7 || i == 15) begin
        vectors++;
        if (bus8.exp_par !== 2'b00) begin
          miscompares++;
          $display("FAIL b2b_exp_par%0d: got %b want 00", i, bus8.exp_par);
        end
      end
    end
    @(negedge clk); #1;
    vectors++;
    if ({bus8.bit_valid, bus8.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle: got %b want 00", {bus8.bit_valid, bus8.busy});
    end
  endtask

  task automatic test_stall;
    logic [7:0] w = 8'hA5;
    logic [4:0] exp;
    int         k;
    logic       st;
    @(negedge clk); bus8.in_data = w; bus8.in_valid = 1'b1; #1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
      st = (c >= 3) && (c <= 5);
      bus8.stall = st;
      #1;
      if (st) begin
        exp = 5'b0_0_0_0_1;
      end else begin
        k   = (c < 3) ? c : c - 3;
        exp = {1'b1, w[7-k], k == 7, k == 7, 1'b1};
      end
      vectors++;
      if ({bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy} !== exp) begin
        miscompares++;
        $display("FAIL stall_cyc%0d: got %b want %b", c, {bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy}, exp);
      end
    end
    vectors++;
    if (bus8.exp_par !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_exp_par: got %b want 00", bus8.exp_par);
    end
    bus8.stall = 1'b0;
  endtask

  task automatic test_stall_last;
    logic [7:0] w0 = 8'h07;
    logic [7:0] w1 = 8'h3C;
    logic [4:0] exp;
    @(negedge clk); bus8.in_data = w0; bus8.in_valid = 1'b1; bus8.stall = 1'b0; #1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); bus8.in_valid = 1'b0; #1;
      exp = {1'b1, w0[7-i], 1'b0, 1'b0, 1'b1};
      vectors++;
      if ({bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy} !== exp) begin
        miscompares++;
        $display("FAIL stlast_bit%0d: got %b want %b", i, {bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy}, exp);
      end
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); bus8.stall = 1'b1; bus8.in_data = w1; bus8.in_valid = 1'b1; #1;
      vectors++;
      if ({bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy} !== 5'b01001) begin
        miscompares++;
        $display("FAIL stlast_hold%0d: got %b want 01001", s, {bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy});
      end
    end
    @(negedge clk); bus8.stall = 1'b0; #1;
    vectors++;
    if ({bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy, bus8.exp_par} !== 7'b11111_11) begin
      miscompares++;
      $display("FAIL stlast_release: got %b want 1111111", {bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy, bus8.exp_par});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus8.in_valid = 1'b0; #1;
      exp = {1'b1, w1[7-i], i == 7, i == 7, 1'b1};
      vectors++;
      if ({bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy} !== exp) begin
        miscompares++;
        $display("FAIL stlast_next%0d: got %b want %b", i, {bus8.bit_valid, bus8.bit_out, bus8.bit_last, bus8.in_ready, bus8.busy}, exp);
      end
      if (i == 0) begin
        vectors++;
        if (bus8.exp_par !== 2'b00) begin
          miscompares++;
          $display("FAIL stlast_next_par: got %b want 00", bus8.exp_par);
        end
      end
    end
  endtask

  task automatic test_lsb_first_reset;
    logic [4:0] w = 5'b00011;
    logic [4:0] exp;
    @(negedge clk); bus5.in_data = w; bus5.in_valid = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus5.in_valid = 1'b0; #1;
      exp = {1'b1, w[i], i == 4, i == 4, 1'b1};
      vectors++;
      if ({bus5.bit_valid, bus5.bit_out, bus5.bit_last, bus5.in_ready, bus5.busy} !== exp) begin
        miscompares++;
        $display("FAIL lsb_bit%0d: got %b want %b", i, {bus5.bit_valid, bus5.bit_out, bus5.bit_last, bus5.in_ready, bus5.busy}, exp);
      end
      if (i == 4) begin
        vectors++;
        if (bus5.exp_par !== 2'b10) begin
          miscompares++;
          $display("FAIL lsb_exp_par: got %b want 10", bus5.exp_par);
        end
      end
    end
    @(negedge clk); bus5.in_valid = 1'b1; #1;
    vectors++;
    if ({bus5.in_ready, bus5.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL lsb_reaccept: got %b want 10", {bus5.in_ready, bus5.busy});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus5.in_valid = 1'b0; #1;
      exp = {1'b1, w[i], 1'b0, 1'b0, 1'b1};
      vectors++;
      if ({bus5.bit_valid, bus5.bit_out, bus5.bit_last, bus5.in_ready, bus5.busy} !== exp) begin
        miscompares++;
        $display("FAIL lsb_pre_rst%0d: got %b want %b", i, {bus5.bit_valid, bus5.bit_out, bus5.bit_last, bus5.in_ready, bus5.busy}, exp);
      end
    end
    @(negedge clk); rst5 = 1'b1; #1;
    vectors++;
    if ({bus5.bit_valid, bus5.bit_out, bus5.bit_last, bus5.in_ready, bus5.busy, bus5.exp_par} !== 7'b0) begin
      miscompares++;
      $display("FAIL lsb_mid_reset: got %b want 0000000", {bus5.bit_valid, bus5.bit_out, bus5.bit_last, bus5.in_ready, bus5.busy, bus5.exp_par});
    end
    @(negedge clk);
    @(negedge clk); rst5 = 1'b0; #1;
    vectors++;
    if ({bus5.bit_valid, bus5.bit_last, bus5.in_ready, bus5.busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL lsb_post_reset: got %b want 0010", {bus5.bit_valid, bus5.bit_last, bus5.in_ready, bus5.busy});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({bus5.bit_valid, bus5.bit_last, bus5.busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL lsb_no_resume%0d: got %b want 000", i, {bus5.bit_valid, bus5.bit_last, bus5.busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_stall_last();
    test_lsb_first_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
